// File: rtl/jk_bank_pkg.sv
// +--------------------------------------------------------------------+
// | jk_bank_pkg : J-K encodings and next-state helper for jk_flipflop_bank |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package jk_bank_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      JK_HOLD: r = q;
      JK_CLR:  r = 1'b0;
      JK_SET:  r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// +--------------------------------------------------------------------+
// | tick_prescaler : free-running divide-by-DIV clock-enable strobe      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tick_prescaler #(
  parameter int DIV = 25_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_div_check
    $error("tick_prescaler: DIV must be >= 1");
  end

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // tick is the combinational strobe for the cycle in which count wraps
  always_comb begin
    tick    = en && (count_q == LAST);
    count_d = count_q;
    if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/jk_flipflop_bank.sv
// +--------------------------------------------------------------------+
// | jk_flipflop_bank : WIDTH J-K flops with input sync, load, change flags |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module jk_flipflop_bank
  import jk_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIV         = 25_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tick,
  output logic [WIDTH-1:0] changed
);

  if (WIDTH < 1 || DIV < 1 || SYNC_STAGES < 2) begin : g_param_check
    $error("jk_flipflop_bank: need WIDTH>=1, DIV>=1, SYNC_STAGES>=2");
  end

  logic             strobe;
  logic [WIDTH-1:0] jk_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             tick_q, tick_d;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (en),
    .tick    (strobe)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] js_q, js_d;
    logic [SYNC_STAGES-1:0] ks_q, ks_d;

    always_comb begin
      js_d = {js_q[SYNC_STAGES-2:0], j[i]};
      ks_d = {ks_q[SYNC_STAGES-2:0], k[i]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        js_q <= '0;
        ks_q <= '0;
      end else begin
        js_q <= js_d;
        ks_q <= ks_d;
      end
    end

    assign jk_d[i] = jk_next(state_q[i], js_q[SYNC_STAGES-1], ks_q[SYNC_STAGES-1]);
  end

  // load overrides a coincident strobe; changed is zero whenever q is untouched
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_data;
    end else if (strobe) begin
      state_d = jk_d;
    end
    changed_d = state_d ^ state_q;
    tick_d    = strobe;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= '0;
      changed_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      changed_q <= changed_d;
      tick_q    <= tick_d;
    end
  end

  assign q       = state_q;
  assign qbar    = ~state_q;
  assign tick    = tick_q;
  assign changed = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_flipflop_bank.sv
// +--------------------------------------------------------------------+
// | tb_jk_flipflop_bank : directed vector bench for jk_flipflop_bank     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_jk_flipflop_bank;

  localparam int W = 4;
  localparam int NV = 38;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic [W-1:0] load_data = '0;
  logic [W-1:0] q, qbar, changed;
  logic         tick;

  int n_vec = 0;
  int n_bad = 0;

  always #10 clock = ~clock;

  jk_flipflop_bank #(
    .WIDTH       (W),
    .DIV         (4),
    .SYNC_STAGES (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .j         (j),
    .k         (k),
    .load      (load),
    .load_data (load_data),
    .q         (q),
    .qbar      (qbar),
    .tick      (tick),
    .changed   (changed)
  );

  typedef struct {
    logic         en;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         load;
    logic [W-1:0] ld;
    logic [W-1:0] exp_q;
    logic         exp_tick;
    logic [W-1:0] exp_chg;
  } vec_t;

  vec_t tbl [NV];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] eq, input logic et,
                           input logic [W-1:0] ec);
    check({tag, ".q"}, q, eq);
    check({tag, ".qbar"}, qbar, ~eq);
    check({tag, ".tick"}, {3'b000, tick}, {3'b000, et});
    check({tag, ".changed"}, changed, ec);
  endtask

  task automatic setv(input int i, input logic e, input logic [W-1:0] vj, input logic [W-1:0] vk,
                      input logic l, input logic [W-1:0] ld, input logic [W-1:0] eq,
                      input logic et, input logic [W-1:0] ec);
    tbl[i] = '{e, vj, vk, l, ld, eq, et, ec};
  endtask

  initial begin
    int  n;
    bit  got;

    // period-4 prescaler, en pause at count 2, set, toggle, set/clear, hold, load
    setv( 0, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv( 1, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv( 2, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv( 3, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 4'h0);
    setv( 4, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv( 5, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv( 6, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv( 7, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv( 8, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv( 9, 1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 1, 4'h0);
    setv(10, 1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv(11, 1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv(12, 1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0);
    setv(13, 1, 4'hF, 4'h0, 0, 4'h0, 4'hF, 1, 4'hF);
    setv(14, 1, 4'hF, 4'hF, 0, 4'h0, 4'hF, 0, 4'h0);
    setv(15, 1, 4'hF, 4'hF, 0, 4'h0, 4'hF, 0, 4'h0);
    setv(16, 1, 4'hF, 4'hF, 0, 4'h0, 4'hF, 0, 4'h0);
    setv(17, 1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 1, 4'hF);
    setv(18, 1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 0, 4'h0);
    setv(19, 1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 0, 4'h0);
    setv(20, 1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 0, 4'h0);
    setv(21, 1, 4'hF, 4'hF, 0, 4'h0, 4'hF, 1, 4'hF);
    setv(22, 1, 4'h5, 4'hA, 0, 4'h0, 4'hF, 0, 4'h0);
    setv(23, 1, 4'h5, 4'hA, 0, 4'h0, 4'hF, 0, 4'h0);
    setv(24, 1, 4'h5, 4'hA, 0, 4'h0, 4'hF, 0, 4'h0);
    setv(25, 1, 4'h5, 4'hA, 0, 4'h0, 4'h5, 1, 4'hA);
    setv(26, 1, 4'h0, 4'h0, 0, 4'h0, 4'h5, 0, 4'h0);
    setv(27, 1, 4'h0, 4'h0, 0, 4'h0, 4'h5, 0, 4'h0);
    setv(28, 1, 4'h0, 4'h0, 0, 4'h0, 4'h5, 0, 4'h0);
    setv(29, 1, 4'h0, 4'h0, 0, 4'h0, 4'h5, 1, 4'h0);
    setv(30, 1, 4'hF, 4'hF, 1, 4'h3, 4'h3, 0, 4'h6);
    setv(31, 1, 4'hF, 4'hF, 0, 4'h0, 4'h3, 0, 4'h0);
    setv(32, 1, 4'hF, 4'hF, 0, 4'h0, 4'h3, 0, 4'h0);
    setv(33, 1, 4'hF, 4'hF, 1, 4'hA, 4'hA, 1, 4'h9);
    setv(34, 1, 4'hF, 4'hF, 0, 4'h0, 4'hA, 0, 4'h0);
    setv(35, 1, 4'hF, 4'hF, 0, 4'h0, 4'hA, 0, 4'h0);
    setv(36, 1, 4'hF, 4'hF, 0, 4'h0, 4'hA, 0, 4'h0);
    setv(37, 1, 4'hF, 4'hF, 0, 4'h0, 4'h5, 1, 4'hF);

    // reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      en        = 1'($urandom_range(0, 1));
      load      = 1'($urandom_range(0, 1));
      j         = W'($urandom_range(0, 15));
      k         = W'($urandom_range(0, 15));
      load_data = W'($urandom_range(0, 15));
      @(negedge clock);
      check_all($sformatf("rst%0d", c), 4'h0, 1'b0, 4'h0);
    end
    en = 1'b0; load = 1'b0; j = '0; k = '0; load_data = '0;
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      en        = tbl[i].en;
      j         = tbl[i].j;
      k         = tbl[i].k;
      load      = tbl[i].load;
      load_data = tbl[i].ld;
      @(negedge clock);
      check_all($sformatf("v%0d", i), tbl[i].exp_q, tbl[i].exp_tick, tbl[i].exp_chg);
    end

    // drive q to 1111, then async reset between edges mid-count
    en = 1'b1; load = 1'b0; j = 4'hF; k = 4'h0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clock);
      if (tick) got = 1'b1;
    end
    check("t6.tick_seen", {3'b000, got}, 4'b0001);
    check("t6.q_set", q, 4'hF);
    @(negedge clock);
    @(negedge clock);
    #3 reset_n = 1'b0;
    #3;
    check_all("t6.async", 4'h0, 1'b0, 4'h0);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (tick) begin
        n = c;
        break;
      end
    end
    check("t6.first_tick", W'(n), 4'd4);
    check("t6.q_after", q, 4'hF);
    check("t6.chg_after", changed, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
